// File: rtl/seg_display_scheduler.sv
// seg_display_scheduler
// Round-robin owner of the shared 4-digit 7-segment display. One requester
// holds the display for a fixed dwell. Its 16-bit value is scanned out one
// digit at a time. All outputs are active-high; pin inversion happens downstream.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | no requester granted; grant, sel and seg are all zero
// ST_SHOW | requester r_gidx owns the display; dwell counter running

module seg_display_scheduler #(
    parameter int DWELL_CYCLES = 100_000_000,
    parameter int SCAN_CYCLES  = 200
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  req,
    input  logic [63:0] data,
    input  logic        hex,
    output logic [3:0]  grant,
    output logic [3:0]  sel,
    output logic [7:0]  seg
);

    localparam int DW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam int SW = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_CYCLES - 1);
    localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_CYCLES - 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SHOW = 1'b1
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [1:0]    r_gidx;
    logic [1:0]    w_gidx_nxt;
    logic [3:0]    r_grant;
    logic [3:0]    w_grant_nxt;
    logic [1:0]    r_rr_ptr;
    logic [1:0]    w_rr_nxt;
    logic [DW-1:0] r_dwell;
    logic [DW-1:0] w_dwell_nxt;

    logic [SW-1:0] r_scan;
    logic [1:0]    r_digit;

    logic [3:0]    r_sel;
    logic [3:0]    w_sel_nxt;
    logic [7:0]    r_seg;
    logic [7:0]    w_seg_nxt;

    logic [3:0]    w_req_oth;
    logic          w_any_vld;
    logic [1:0]    w_any_idx;
    logic          w_oth_vld;
    logic [1:0]    w_oth_idx;
    logic [3:0]    w_nib;

    // Cyclic search from start; descending loop lets the closest index win.
    function automatic logic [2:0] rr_pick(input logic [3:0] mask, input logic [1:0] start);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int k = 3; k >= 0; k--) begin
            idx = start + 2'(k);
            if (mask[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    // Standard glyphs; A-F only render in hex mode, otherwise blank.
    function automatic logic [6:0] glyph(input logic [3:0] nib, input logic hex_mode);
        logic [6:0] g;
        case (nib)
            4'h0: g = 7'h3F;
            4'h1: g = 7'h06;
            4'h2: g = 7'h5B;
            4'h3: g = 7'h4F;
            4'h4: g = 7'h66;
            4'h5: g = 7'h6D;
            4'h6: g = 7'h7D;
            4'h7: g = 7'h07;
            4'h8: g = 7'h7F;
            4'h9: g = 7'h6F;
            4'hA: g = 7'h77;
            4'hB: g = 7'h7C;
            4'hC: g = 7'h39;
            4'hD: g = 7'h5E;
            4'hE: g = 7'h79;
            default: g = 7'h71;
        endcase
        if (!hex_mode && (nib > 4'd9)) begin
            g = 7'h00;
        end
        return g;
    endfunction

    // Dwell expiry hands over to someone else, so the current owner is masked out.
    assign w_req_oth = req & ~(4'b0001 << r_gidx);
    assign {w_any_vld, w_any_idx} = rr_pick(req, r_rr_ptr);
    assign {w_oth_vld, w_oth_idx} = rr_pick(w_req_oth, r_rr_ptr);

    // Arbitration next state: grant, round-robin pointer and dwell counter.
    always_comb begin
        w_state_nxt = r_state;
        w_gidx_nxt  = r_gidx;
        w_grant_nxt = r_grant;
        w_rr_nxt    = r_rr_ptr;
        w_dwell_nxt = r_dwell;
        case (r_state)
            ST_IDLE: begin
                if (w_any_vld) begin
                    w_state_nxt = ST_SHOW;
                    w_gidx_nxt  = w_any_idx;
                    w_grant_nxt = 4'b0001 << w_any_idx;
                    w_rr_nxt    = w_any_idx + 2'd1;
                    w_dwell_nxt = '0;
                end
            end
            ST_SHOW: begin
                if (!req[r_gidx]) begin
                    // Owner withdrew: this takes priority over a coincident dwell expiry.
                    w_dwell_nxt = '0;
                    if (w_any_vld) begin
                        w_gidx_nxt  = w_any_idx;
                        w_grant_nxt = 4'b0001 << w_any_idx;
                        w_rr_nxt    = w_any_idx + 2'd1;
                    end else begin
                        w_state_nxt = ST_IDLE;
                        w_grant_nxt = 4'b0000;
                    end
                end else if (r_dwell == DWELL_LAST) begin
                    w_dwell_nxt = '0;
                    if (w_oth_vld) begin
                        w_gidx_nxt  = w_oth_idx;
                        w_grant_nxt = 4'b0001 << w_oth_idx;
                        w_rr_nxt    = w_oth_idx + 2'd1;
                    end
                end else begin
                    w_dwell_nxt = r_dwell + 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_grant_nxt = 4'b0000;
                w_dwell_nxt = '0;
            end
        endcase
    end

    // Arbitration state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_gidx   <= 2'd0;
            r_grant  <= 4'b0000;
            r_rr_ptr <= 2'd0;
            r_dwell  <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_gidx   <= w_gidx_nxt;
            r_grant  <= w_grant_nxt;
            r_rr_ptr <= w_rr_nxt;
            r_dwell  <= w_dwell_nxt;
        end
    end

    // Free-running digit scan; deliberately not restarted on grant changes.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_scan  <= '0;
            r_digit <= 2'd0;
        end else if (r_scan == SCAN_LAST) begin
            r_scan  <= '0;
            r_digit <= r_digit + 2'd1;
        end else begin
            r_scan  <= r_scan + 1'b1;
        end
    end

    // Live data of the owner (not latched at grant) for the digit being scanned.
    assign w_nib = data[{r_gidx, r_digit, 2'b00} +: 4];

    // Display outputs from current grant/digit/data; dp marks the owner's index.
    always_comb begin
        w_sel_nxt = 4'b0000;
        w_seg_nxt = 8'h00;
        if (r_grant != 4'b0000) begin
            w_sel_nxt = 4'b0001 << r_digit;
            w_seg_nxt = {(r_digit == r_gidx), glyph(w_nib, hex)};
        end
    end

    // One-cycle output register in front of the pins.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sel <= 4'b0000;
            r_seg <= 8'h00;
        end else begin
            r_sel <= w_sel_nxt;
            r_seg <= w_seg_nxt;
        end
    end

    assign grant = r_grant;
    assign sel   = r_sel;
    assign seg   = r_seg;

endmodule

// File: tb/tb_seg_display_scheduler.sv
// tb_seg_display_scheduler
// Directed scenarios plus randomized traffic, all checked every cycle against
// an owner/countdown reference model held as plain integers.

module tb_seg_display_scheduler;

    localparam int DWELL = 8;
    localparam int SCAN  = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req = 4'b0000;
    logic [63:0] data = 64'h0;
    logic        hex = 1'b0;
    logic [3:0]  grant;
    logic [3:0]  sel;
    logic [7:0]  seg;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: owner index (-1 = nobody), rotation start, dwell age,
    // scan position, plus the values the output pins should show.
    int         m_own   = -1;
    int         m_rr    = 0;
    int         m_dwell = 0;
    int         m_scan  = 0;
    int         m_digit = 0;
    logic [3:0] m_sel   = 4'b0000;
    logic [7:0] m_seg   = 8'h00;

    logic [6:0] glyph_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                   7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    seg_display_scheduler #(
        .DWELL_CYCLES(DWELL),
        .SCAN_CYCLES (SCAN)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .req  (req),
        .data (data),
        .hex  (hex),
        .grant(grant),
        .sel  (sel),
        .seg  (seg)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int pick(input logic [3:0] mask, input int start);
        for (int k = 0; k < 4; k++) begin
            if (mask[(start + k) % 4]) return (start + k) % 4;
        end
        return -1;
    endfunction

    function automatic logic [3:0] onehot(input int i);
        return (i < 0) ? 4'b0000 : 4'(1 << i);
    endfunction

    task automatic model_step();
        logic [3:0] nib;
        logic [3:0] oth;
        if (rst) begin
            m_own = -1; m_rr = 0; m_dwell = 0; m_scan = 0; m_digit = 0;
            m_sel = 4'b0000; m_seg = 8'h00;
        end else begin
            if (m_own >= 0) begin
                nib   = data[16*m_own + 4*m_digit +: 4];
                m_sel = onehot(m_digit);
                m_seg = {(m_digit == m_own), (hex || nib < 10) ? glyph_tab[nib] : 7'h00};
            end else begin
                m_sel = 4'b0000;
                m_seg = 8'h00;
            end
            m_scan++;
            if (m_scan == SCAN) begin
                m_scan  = 0;
                m_digit = (m_digit + 1) % 4;
            end
            if (m_own < 0) begin
                if (req != 0) begin
                    m_own = pick(req, m_rr); m_rr = (m_own + 1) % 4; m_dwell = 0;
                end
            end else if (!req[m_own]) begin
                m_dwell = 0;
                if (req != 0) begin
                    m_own = pick(req, m_rr); m_rr = (m_own + 1) % 4;
                end else begin
                    m_own = -1;
                end
            end else if (m_dwell == DWELL - 1) begin
                m_dwell = 0;
                oth = req & ~onehot(m_own);
                if (oth != 0) begin
                    m_own = pick(oth, m_rr); m_rr = (m_own + 1) % 4;
                end
            end else begin
                m_dwell++;
            end
        end
    endtask

    // One clock: model follows the edge, pins are compared on the falling edge.
    task automatic step();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_eq("grant", grant, onehot(m_own));
        check_eq("sel", sel, m_sel);
        check_eq("seg", seg, m_seg);
    endtask

    function automatic logic [7:0] seg_by_sel(input logic [3:0] s, input logic [31:0] tab);
        case (s)
            4'b0001: return tab[7:0];
            4'b0010: return tab[15:8];
            4'b0100: return tab[23:16];
            default: return tab[31:24];
        endcase
    endfunction

    initial begin
        int run;
        int changes;
        logic [3:0] prev;
        bit found;

        // Reset, then idle with no requests.
        rst = 1'b1;
        step();
        step();
        check_eq("rst_grant", grant, 4'b0000);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            check_eq("idle_seg", seg, 8'h00);
        end

        // Single requester, decimal digits 1234.
        data[15:0] = 16'h1234;
        hex = 1'b0;
        req = 4'b0001;
        step();
        check_eq("grant_first", grant, 4'b0001);
        step();
        for (int i = 0; i < 16; i++) begin
            step();
            check_eq("seg_1234", seg, seg_by_sel(sel, 32'h06_5B_4F_E6));
        end

        // Two requesters alternate with equal dwell.
        data[47:32] = 16'h5678;
        req = 4'b0101;
        run = 0; changes = 0; prev = grant;
        for (int i = 0; i < 50; i++) begin
            step();
            if (grant != prev) begin
                if (changes > 0) check_eq("run_len", run, DWELL);
                changes++;
                run = 0;
            end
            run++;
            prev = grant;
        end
        check_eq("alt_seen", (changes >= 4), 1);

        // Owner drops while another waits: immediate handover.
        req = 4'b1001;
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            step();
            if (m_own == 0 && m_dwell == 3) found = 1'b1;
        end
        check_eq("dwell3_reached", found, 1);
        req = 4'b1000;
        step();
        check_eq("drop_handover", grant, 4'b1000);
        for (int i = 0; i < 30; i++) begin
            step();
            check_eq("hold_alone", grant, 4'b1000);
        end

        // Hex vs decimal rendering of 00AF.
        data[15:0] = 16'h00AF;
        hex = 1'b1;
        req = 4'b0001;
        for (int i = 0; i < 4; i++) step();
        for (int i = 0; i < 8; i++) begin
            step();
            check_eq("hex_af", seg, seg_by_sel(sel, 32'h3F_3F_77_F1));
        end
        hex = 1'b0;
        step();
        for (int i = 0; i < 8; i++) begin
            step();
            check_eq("dec_af", seg, seg_by_sel(sel, 32'h3F_3F_00_80));
        end

        // Reset mid-grant, then restart arbitration from index 0.
        rst = 1'b1;
        step();
        check_eq("rst_mid_grant", grant, 4'b0000);
        check_eq("rst_mid_sel", sel, 4'b0000);
        check_eq("rst_mid_seg", seg, 8'h00);
        rst = 1'b0;
        req = 4'b0110;
        step();
        check_eq("post_rst_grant", grant, 4'b0010);

        // Randomized traffic.
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 7) == 0) req = 4'($urandom);
            if ($urandom_range(0, 5) == 0) data = {$urandom, $urandom};
            if ($urandom_range(0, 30) == 0) hex = ~hex;
            rst = ($urandom_range(0, 299) == 0);
            step();
        end
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
